fir_mac_seq: RTL and testbench

Parametrised, multi-channel, time-multiplexed FIR MAC engine. It is the successor to the fixed two-channel 16-bit low-pass filter. On a `start` pulse it walks `NUM_TAPS` coefficient addresses, multiplies each coefficient by the matching sample from every channel, and accumulates at full precision. It then rounds, saturates and presents one output sample per channel with a single-cycle valid. Coefficient ROMs and sample circular queues sit outside the block; it sits between the queues and the audio output path, one instance per filter band.

---
 rtl/fir_mac_seq.sv | 149 ++++++++++++++
 tb/tb_fir_mac_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_mac_seq : time-multiplexed multi-channel FIR MAC, round + saturate    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fir_mac_seq #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 1021,
  parameter int NUM_CH   = 2,
  parameter int FRAC     = 15,
  parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  input  logic [COEF_W-1:0]        coef_in,
  output logic [ADDR_W-1:0]        coef_addr,
  output logic                     smpl_rd,
  output logic                     busy,
  output logic                     out_vld,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic [NUM_CH-1:0]        sat
);

  localparam int c_prod_w = DATA_W + COEF_W;
  localparam int c_acc_w  = c_prod_w + ADDR_W;
  localparam int c_rnd_w  = c_acc_w + 1;
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NUM_TAPS - 1);
  localparam logic signed [c_rnd_w-1:0] c_half = c_rnd_w'(1) <<< (FRAC - 1);
  localparam logic signed [c_rnd_w-1:0] c_max =
    {{(c_rnd_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [c_rnd_w-1:0] c_min =
    {{(c_rnd_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] c_max_out = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] c_min_out = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_ROUND = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]        r_addr;
  logic                     r_acc_en;
  logic                     r_vld;
  logic [NUM_CH*DATA_W-1:0] r_dout;
  logic [NUM_CH-1:0]        r_sat;
  logic signed [c_acc_w-1:0]  r_acc [NUM_CH];
  logic signed [c_prod_w-1:0] w_prod [NUM_CH];
  logic [DATA_W-1:0]          w_res [NUM_CH];
  logic [NUM_CH-1:0]          w_clip;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    smpl_rd = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        smpl_rd = 1'b1;
        if (r_addr == c_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_ROUND;
      end
      S_ROUND: begin
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-channel product against the shared coefficient, then round half up and clip.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [DATA_W-1:0]  w_smp;
    logic signed [c_rnd_w-1:0] w_rnd;
    logic signed [c_rnd_w-1:0] w_shr;
    logic                      w_hi;
    logic                      w_lo;

    assign w_smp     = smpl_in[c*DATA_W +: DATA_W];
    assign w_prod[c] = w_smp * $signed(coef_in);
    assign w_rnd     = {r_acc[c][c_acc_w-1], r_acc[c]} + c_half;
    assign w_shr     = w_rnd >>> FRAC;
    assign w_hi      = (w_shr > c_max);
    assign w_lo      = (w_shr < c_min);
    assign w_res[c]  = w_hi ? c_max_out : (w_lo ? c_min_out : w_shr[DATA_W-1:0]);
    assign w_clip[c] = w_hi | w_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_acc_en <= 1'b0;
      r_vld    <= 1'b0;
      r_dout   <= '0;
      r_sat    <= '0;
      for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
    end else begin
      r_vld    <= 1'b0;
      // Upstream ROM and queue are registered, so data lags the address by one cycle.
      r_acc_en <= (r_state == S_RUN);
      if (r_acc_en) begin
        for (int c = 0; c < NUM_CH; c++)
          r_acc[c] <= r_acc[c] + {{ADDR_W{w_prod[c][c_prod_w-1]}}, w_prod[c]};
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= '0;
            for (int c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
          end
        end
        S_RUN: begin
          r_addr <= (r_addr == c_last) ? '0 : r_addr + ADDR_W'(1);
        end
        S_ROUND: begin
          for (int c = 0; c < NUM_CH; c++) r_dout[c*DATA_W +: DATA_W] <= w_res[c];
          r_sat <= w_clip;
          r_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign coef_addr = r_addr;
  assign out_vld   = r_vld;
  assign dout      = r_dout;
  assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_mac_seq : bench for fir_mac_seq (N=4 and N=1021 instances)         |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fir_mac_seq;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int NA  = 4;
  localparam int NB  = 1021;
  localparam int NCH = 2;
  localparam int AWA = $clog2(NA);
  localparam int AWB = $clog2(NB);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  start_a, start_b;
  logic [NCH*DW-1:0]     smpl_a, smpl_b, dout_a, dout_b;
  logic [CW-1:0]         coef_a, coef_b;
  logic [AWA-1:0]        addr_a;
  logic [AWB-1:0]        addr_b;
  logic                  rd_a, busy_a, vld_a, rd_b, busy_b, vld_b;
  logic [NCH-1:0]        sat_a, sat_b;

  int rom_a [NA];
  int smp_a [NCH][NA];
  int rom_b [NB];
  int smp_b [NCH][NB];

  int total = 0;
  int bad   = 0;

  fir_mac_seq #(.DATA_W(DW), .COEF_W(CW), .NUM_TAPS(NA), .NUM_CH(NCH), .FRAC(15)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .smpl_in(smpl_a), .coef_in(coef_a),
    .coef_addr(addr_a), .smpl_rd(rd_a), .busy(busy_a), .out_vld(vld_a),
    .dout(dout_a), .sat(sat_a)
  );

  fir_mac_seq #(.DATA_W(DW), .COEF_W(CW), .NUM_TAPS(NB), .NUM_CH(NCH), .FRAC(15)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .smpl_in(smpl_b), .coef_in(coef_b),
    .coef_addr(addr_b), .smpl_rd(rd_b), .busy(busy_b), .out_vld(vld_b),
    .dout(dout_b), .sat(sat_b)
  );

  // Registered coefficient ROM and sample source: data for address k arrives a cycle later.
  always @(posedge clk) begin
    coef_a <= CW'(rom_a[addr_a]);
    coef_b <= CW'(rom_b[addr_b]);
    for (int c = 0; c < NCH; c++) begin
      smpl_a[c*DW +: DW] <= DW'(smp_a[c][addr_a]);
      smpl_b[c*DW +: DW] <= DW'(smp_b[c][addr_b]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact dot product, round half up, clip to the signed output range.
  function automatic logic [DW:0] model(input longint acc);
    longint r;
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic logic [DW:0] exp_a(input int c);
    longint acc = 0;
    for (int k = 0; k < NA; k++) acc += longint'(rom_a[k]) * longint'(smp_a[c][k]);
    return model(acc);
  endfunction

  function automatic logic [DW:0] exp_b(input int c);
    longint acc = 0;
    for (int k = 0; k < NB; k++) acc += longint'(rom_b[k]) * longint'(smp_b[c][k]);
    return model(acc);
  endfunction

  task automatic fill_a(input int coef, input int s0, input int s1);
    for (int k = 0; k < NA; k++) begin
      rom_a[k] = coef; smp_a[0][k] = s0; smp_a[1][k] = s1;
    end
  endtask

  task automatic rand_a(input int span);
    for (int k = 0; k < NA; k++) begin
      rom_a[k] = int'($urandom_range(0, 2*span)) - span;
      for (int c = 0; c < NCH; c++) smp_a[c][k] = int'($urandom_range(0, 2*span)) - span;
    end
  endtask

  task automatic check_out_a(input string tag);
    logic [DW:0] e;
    for (int c = 0; c < NCH; c++) begin
      e = exp_a(c);
      chk($sformatf("%s_dout%0d", tag, c), dout_a[c*DW +: DW], e[DW-1:0]);
      chk($sformatf("%s_sat%0d", tag, c), sat_a[c], e[DW]);
    end
  endtask

  // One convolution on the N=4 instance; ign adds stray start pulses in cycles 2 and N+1.
  task automatic run_a(input string tag, input bit ign);
    int lat = -1, nrd = 0, nbusy = 0, abad = 0, extra = 0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 1; i <= NA + 20; i++) begin
      if (rd_a) begin
        nrd++;
        if (addr_a !== AWA'(i - 1)) abad++;
      end
      if (busy_a) nbusy++;
      if (vld_a) begin lat = i; break; end
      start_a = ign && (i == 2 || i == NA + 1);
      @(negedge clk);
    end
    start_a = 1'b0;
    chk({tag, "_latency"}, lat, NA + 3);
    chk({tag, "_rd_count"}, nrd, NA);
    chk({tag, "_busy_count"}, nbusy, NA + 2);
    chk({tag, "_addr_seq"}, abad, 0);
    check_out_a(tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld_a || busy_a) extra++;
    end
    chk({tag, "_quiet_after"}, extra, 0);
  endtask

  initial begin
    logic [DW:0] e;
    int cnt, abad, exp_addr, first, second, nrd1, nrd2, outbad;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < NA; k++) begin rom_a[k] = 0; smp_a[0][k] = 0; smp_a[1][k] = 0; end
    for (int k = 0; k < NB; k++) begin rom_b[k] = 0; smp_b[0][k] = 0; smp_b[1][k] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_vld", vld_a, 1'b0);
    chk("rst_rd", rd_a, 1'b0);
    chk("rst_addr", addr_a, '0);
    chk("rst_dout", dout_a, '0);
    chk("rst_sat", sat_a, '0);

    fill_a(32'sh4000, 32'sh1000, 32'sh1000);
    run_a("unity_half", 1'b0);
    chk("unity_half_const", dout_a, {16'h2000, 16'h2000});

    fill_a(32'sh7FFF, 32'sh7FFF, 32'sh7FFF);
    run_a("sat_pos", 1'b0);
    chk("sat_pos_const", {sat_a, dout_a}, {2'b11, 16'h7FFF, 16'h7FFF});

    fill_a(32'sh7FFF, -32768, -32768);
    run_a("sat_neg", 1'b0);
    chk("sat_neg_const", {sat_a, dout_a}, {2'b11, 16'h8000, 16'h8000});

    fill_a(0, 0, 0);
    rom_a[0] = 1; smp_a[0][0] = 32'sh4000; smp_a[1][0] = -32'sh4000;
    run_a("round", 1'b0);
    chk("round_const", {sat_a, dout_a}, {2'b00, 16'h0000, 16'h0001});

    rand_a(20000);
    run_a("ignore_start", 1'b1);

    for (int t = 0; t < 6; t++) begin
      rand_a((t % 2 == 0) ? 32767 : 8000);
      run_a($sformatf("rand%0d", t), 1'b0);
    end

    // Reset asserted during RUN cycle 3 aborts the convolution.
    rand_a(12000);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_vld", vld_a, 1'b0);
    chk("abort_dout", dout_a, '0);
    chk("abort_addr", addr_a, '0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vld_a || busy_a) cnt++;
    end
    chk("abort_no_vld", cnt, 0);
    run_a("after_abort", 1'b0);

    // Back-to-back on the full-length instance with start held high.
    for (int k = 0; k < NB; k++) begin
      rom_b[k] = int'($urandom_range(0, 2000)) - 1000;
      for (int c = 0; c < NCH; c++) smp_b[c][k] = int'($urandom_range(0, 2000)) - 1000;
    end
    first = -1; second = -1; nrd1 = 0; nrd2 = 0; abad = 0; exp_addr = 0; outbad = 0;
    @(negedge clk); start_b = 1'b1;
    for (int i = 1; i <= 3 * (NB + 3) + 50; i++) begin
      @(negedge clk);
      if (rd_b) begin
        if (first < 0) nrd1++; else nrd2++;
        if (addr_b !== AWB'(exp_addr)) abad++;
        exp_addr = (exp_addr + 1) % NB;
      end
      if (vld_b) begin
        for (int c = 0; c < NCH; c++) begin
          e = exp_b(c);
          if (dout_b[c*DW +: DW] !== e[DW-1:0] || sat_b[c] !== e[DW]) outbad++;
        end
        if (first < 0) first = i;
        else begin second = i; start_b = 1'b0; break; end
      end
    end
    start_b = 1'b0;
    chk("b2b_first_latency", first, NB + 3);
    chk("b2b_period", second - first, NB + 3);
    chk("b2b_rd_count1", nrd1, NB);
    chk("b2b_rd_count2", nrd2, NB);
    chk("b2b_addr_seq", abad, 0);
    chk("b2b_outputs", outbad, 0);
    e = exp_b(0);
    chk("b2b_dout0", dout_b[DW-1:0], e[DW-1:0]);
    repeat (4) @(negedge clk);
    chk("b2b_idle", {busy_b, vld_b}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
